main_mem_ctrl: RTL and testbench
================================

MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 Parameter LAT, default 8: access latency in cycles from request acceptance to first data or write commit; legal range 1..255.
REQ-002 Parameter DEPTH_LOG, default 8: log2 of storage size in 32-bit words; 4 words per line.
REQ-003 cpu_clk  input  1  single clock; all state updates on rising edge.
REQ-004 cpu_rstn  input  1  reset, synchronous, active-high (asserted = 1).
REQ-005 mreq  input  1  line request from the data cache.
REQ-006 mrw  input  1  request type: 0 = line read (refill), 1 = line write (writeback).
REQ-007 maddr  input  32  byte address of the line; bits [3:0] ignored.
REQ-008 wline  input  128  writeback line; word k at bits [32k+31:32k].
REQ-009 mready  output  1  controller idle; request accepted when mreq && mready.
REQ-010 rvalid  output  1  read beat valid.
REQ-011 rdata  output  32  read beat data.
REQ-012 rlast  output  1  final (4th) read beat.
REQ-013 wdone  output  1  one-cycle writeback-complete pulse.
REQ-014 dpra  input  32  debug word address; bits [DEPTH_LOG+1:2] used.
REQ-015 dpo  output  32  debug read data, combinational from dpra.
REQ-016 rd_count, wr_count  output  32 each  accepted read and write request counters.

Function
REQ-017 States: IDLE, WAIT, RBURST, WDONE; mready = 1 only in IDLE.
REQ-018 IDLE: on mreq, latch line index maddr[DEPTH_LOG+1:4], mrw, wline; load latency counter with LAT-1; go to WAIT; mreq in any other state is ignored.
REQ-019 WAIT: counter decrements each cycle; at counter 0 go to RBURST with beat = 0 (read) or write all 4 latched words into storage and go to WDONE (write).
REQ-020 RBURST: rvalid = 1; rdata = word[beat] of latched line; rlast = 1 when beat = 3; beat increments; after beat 3 go to IDLE; no backpressure, the cache accepts every beat.
REQ-021 WDONE: wdone = 1 for exactly one cycle; next state IDLE.
REQ-022 Timing with acceptance edge at cycle T: read beats in cycles T+LAT+1..T+LAT+4, mready high again at T+LAT+5; write wdone at T+LAT+1, mready at T+LAT+2.
REQ-023 rdata = 0 whenever rvalid = 0; rlast and wdone never asserted outside their states.
REQ-024 Address bits above DEPTH_LOG+1 ignored: lines alias modulo 2^(DEPTH_LOG-2).
REQ-025 rd_count/wr_count increment by 1 on acceptance of a read/write; wrap modulo 2^32.
REQ-026 A request present in the cycle rlast or wdone is asserted is not accepted; earliest acceptance is the following cycle.
REQ-027 Read of a line while no write is pending returns the most recently committed contents; data written at WDONE entry is visible to any later read and to dpo.
REQ-028 Storage initialised to all zero at configuration; reset does not clear storage.

Reset
REQ-029 While cpu_rstn = 1 at a rising edge: state = IDLE, counters and beat = 0, rvalid = rlast = wdone = 0, rdata = 0, rd_count = wr_count = 0; mready = 1 the cycle after reset deasserts.
REQ-030 Reset in WAIT or RBURST aborts the access: no further beats, pending write discarded (storage unchanged).

Verification
REQ-031 LAT=8: write maddr=0x40, wline={0x44,0x33,0x22,0x11} at T -> wdone at T+9 only, wr_count=1, dpo(dpra=0x44)=0x22.
REQ-032 Then read maddr=0x4C at T' -> rdata 0x11,0x22,0x33,0x44 in T'+9..T'+12, rlast only at T'+12, mready back at T'+13, rd_count=1.
REQ-033 Hold mreq=1, mrw=0 continuously -> accepted every LAT+5 cycles, no overlap of bursts, rd_count counts each acceptance.
REQ-034 Assert cpu_rstn during beat 2 of a read -> rvalid 0 next cycle, all outputs at reset values, storage intact on following read.
REQ-035 DEPTH_LOG=8: write maddr=0x400 then read maddr=0x000 -> aliased data returned.
REQ-036 LAT=1: read accepted at T -> first beat at T+2, write wdone at T+2.

Source files
------------

// File: rtl/main_mem_ctrl_if.sv
// Cache-to-main-memory line bus: request/writeback from the cache, burst read
// data and write completion back from the controller.
interface main_mem_ctrl_if;
    logic         mreq;
    logic         mrw;
    logic [31:0]  maddr;
    logic [127:0] wline;
    logic         mready;
    logic         rvalid;
    logic [31:0]  rdata;
    logic         rlast;
    logic         wdone;

    modport master (
        output mreq, mrw, maddr, wline,
        input  mready, rvalid, rdata, rlast, wdone
    );

    modport slave (
        input  mreq, mrw, maddr, wline,
        output mready, rvalid, rdata, rlast, wdone
    );
endinterface

// File: rtl/main_mem_ctrl.sv
// Fixed-latency main memory model for a data cache: 4-word line refills as
// beat bursts, whole-line writebacks, and a combinational debug read port.
module main_mem_ctrl #(
    parameter int unsigned LAT       = 8,
    parameter int unsigned DEPTH_LOG = 8
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rstn,
    main_mem_ctrl_if.slave       bus,
    input  logic [31:0]          dpra,
    output logic [31:0]          dpo,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);

    localparam int unsigned IDX_W = DEPTH_LOG - 2;
    localparam int unsigned WORDS = 2 ** DEPTH_LOG;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_RBURST = 2'd2,
        S_WDONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         beat_q, beat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_q, wr_d;
    logic [127:0]       wline_q, wline_d;
    logic               mready_q, mready_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rlast_q, rlast_d;
    logic               wdone_q, wdone_d;
    logic [31:0]        rd_count_q, rd_count_d;
    logic [31:0]        wr_count_q, wr_count_d;
    logic               mem_we_c;

    // Storage comes up zeroed at configuration and is never touched by reset.
    logic [31:0]        mem_q [WORDS] = '{default: '0};

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        wline_d    = wline_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        mem_we_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.mreq) begin
                    idx_d   = bus.maddr[DEPTH_LOG+1:4];
                    wr_d    = bus.mrw;
                    wline_d = bus.wline;
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = S_WAIT;
                    if (bus.mrw) wr_count_d = wr_count_q + 32'd1;
                    else         rd_count_d = rd_count_q + 32'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (wr_q) begin
                        mem_we_c = 1'b1;
                        state_d  = S_WDONE;
                    end else begin
                        beat_d  = 2'd0;
                        state_d = S_RBURST;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RBURST: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = S_IDLE;
            end
            S_WDONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the upcoming state so they register cleanly.
        mready_d = (state_d == S_IDLE);
        rvalid_d = (state_d == S_RBURST);
        rlast_d  = rvalid_d && (beat_d == 2'd3);
        wdone_d  = (state_d == S_WDONE);
        rdata_d  = rvalid_d ? mem_q[{idx_q, beat_d}] : 32'd0;
    end

    // Control and output registers
    always_ff @(posedge cpu_clk) begin
        if (cpu_rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            wline_q    <= '0;
            mready_q   <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rlast_q    <= 1'b0;
            wdone_q    <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            wline_q    <= wline_d;
            mready_q   <= mready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rlast_q    <= rlast_d;
            wdone_q    <= wdone_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Line commit; a reset on the commit edge drops the pending write.
    always_ff @(posedge cpu_clk) begin
        if (mem_we_c && !cpu_rstn) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[{idx_q, 2'(k)}] <= wline_q[32*k +: 32];
            end
        end
    end

    assign bus.mready = mready_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.rlast  = rlast_q;
    assign bus.wdone  = wdone_q;

    assign dpo      = mem_q[dpra[DEPTH_LOG+1:2]];
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

    logic unused_c;
    assign unused_c = ^{bus.maddr[31:DEPTH_LOG+2], bus.maddr[3:0],
                        dpra[31:DEPTH_LOG+2], dpra[1:0]};

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: latency/beat timing, counters, aliasing,
// reset abort, back-to-back requests, and a LAT=1 instance.
module tb_main_mem_ctrl;

    localparam int unsigned L0 = 8;
    localparam int unsigned L1 = 1;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic [31:0] dpra0, dpo0, rdc0, wrc0;
    logic [31:0] dpra1, dpo1, rdc1, wrc1;
    int          checks = 0;
    int          failures = 0;
    int          exp_rd = 0;

    main_mem_ctrl_if bus0 ();
    main_mem_ctrl_if bus1 ();

    main_mem_ctrl #(.LAT(L0), .DEPTH_LOG(8)) dut0 (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .bus(bus0),
        .dpra(dpra0), .dpo(dpo0), .rd_count(rdc0), .wr_count(wrc0)
    );

    main_mem_ctrl #(.LAT(L1), .DEPTH_LOG(8)) dut1 (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .bus(bus1),
        .dpra(dpra1), .dpo(dpo1), .rd_count(rdc1), .wr_count(wrc1)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // Present one request for a single edge; returns just after the acceptance edge.
    task automatic issue0(input logic rw, input logic [31:0] a, input logic [127:0] l);
        bus0.mreq = 1'b1; bus0.mrw = rw; bus0.maddr = a; bus0.wline = l;
        tick();
        bus0.mreq = 1'b0; bus0.mrw = 1'b0; bus0.maddr = '0; bus0.wline = '0;
    endtask

    task automatic test_reset();
        cpu_rstn = 1'b1;
        tick(); tick();
        checks++;
        if ({bus0.mready, bus0.rvalid, bus0.rlast, bus0.wdone, bus0.rdata} !== {4'b1000, 32'd0}) begin
            failures++;
            $display("FAIL reset_outputs got %b_%h exp 1000_00000000",
                     {bus0.mready, bus0.rvalid, bus0.rlast, bus0.wdone}, bus0.rdata);
        end
        checks++;
        if ({rdc0, wrc0} !== 64'd0) begin
            failures++;
            $display("FAIL reset_counters got rd=%0d wr=%0d exp 0 0", rdc0, wrc0);
        end
        cpu_rstn = 1'b0;
        tick();
        checks++;
        if (bus0.mready !== 1'b1 || bus1.mready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mready got %b%b exp 11", bus0.mready, bus1.mready);
        end
    endtask

    task automatic test_write();
        logic [127:0] line;
        line = {32'h44, 32'h33, 32'h22, 32'h11};
        issue0(1'b1, 32'h40, line);
        for (int j = 0; j <= L0 + 1; j++) begin
            checks++;
            if ({bus0.wdone, bus0.mready, bus0.rvalid} !== {(j == L0), (j == L0 + 1), 1'b0}) begin
                failures++;
                $display("FAIL write_timing j=%0d got wdone/mready/rvalid=%b%b%b exp %b%b0",
                         j, bus0.wdone, bus0.mready, bus0.rvalid, (j == L0), (j == L0 + 1));
            end
            if (j <= L0) tick();
        end
        checks++;
        if (wrc0 !== 32'd1 || rdc0 !== 32'd0) begin
            failures++;
            $display("FAIL write_counts got rd=%0d wr=%0d exp 0 1", rdc0, wrc0);
        end
        dpra0 = 32'h44; #1;
        checks++;
        if (dpo0 !== 32'h22) begin
            failures++;
            $display("FAIL write_dpo got %h exp 00000022", dpo0);
        end
    endtask

    task automatic test_read();
        logic [127:0] line;
        logic [34:0]  exp_v;
        int           wi;
        line = {32'h44, 32'h33, 32'h22, 32'h11};
        issue0(1'b0, 32'h4C, '0);
        exp_rd++;
        for (int j = 0; j <= L0 + 4; j++) begin
            wi = (j - L0) & 3;
            exp_v[34] = (j >= L0 && j <= L0 + 3);
            exp_v[33] = (j == L0 + 3);
            exp_v[32] = (j == L0 + 4);
            exp_v[31:0] = exp_v[34] ? line[32*wi +: 32] : 32'd0;
            checks++;
            if ({bus0.rvalid, bus0.rlast, bus0.mready, bus0.rdata} !== exp_v) begin
                failures++;
                $display("FAIL read_beat j=%0d got v/l/r=%b%b%b data=%h exp %b data=%h",
                         j, bus0.rvalid, bus0.rlast, bus0.mready, bus0.rdata, exp_v[34:32], exp_v[31:0]);
            end
            if (j < L0 + 4) tick();
        end
        checks++;
        if (rdc0 !== 32'(exp_rd)) begin
            failures++;
            $display("FAIL read_count got %0d exp %0d", rdc0, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int last;
        acc = 0; last = -1;
        bus0.mreq = 1'b1; bus0.mrw = 1'b0; bus0.maddr = 32'h40;
        for (int c = 0; c < 3 * (L0 + 5); c++) begin
            if (bus0.mready) begin
                if (last >= 0) begin
                    checks++;
                    if (c - last != L0 + 5) begin
                        failures++;
                        $display("FAIL b2b_gap got %0d exp %0d", c - last, L0 + 5);
                    end
                end
                last = c;
                acc++;
            end
            checks++;
            if (bus0.rvalid && (bus0.mready || bus0.wdone)) begin
                failures++;
                $display("FAIL b2b_overlap c=%0d got rvalid/mready/wdone=%b%b%b exp 100",
                         c, bus0.rvalid, bus0.mready, bus0.wdone);
            end
            tick();
        end
        bus0.mreq = 1'b0; bus0.maddr = '0;
        exp_rd += 3;
        checks++;
        if (acc != 3 || bus0.mready !== 1'b1 || rdc0 !== 32'(exp_rd)) begin
            failures++;
            $display("FAIL b2b_count got acc=%0d mready=%b rd=%0d exp 3 1 %0d", acc, bus0.mready, rdc0, exp_rd);
        end
    endtask

    task automatic test_reset_abort();
        logic [127:0] line;
        logic [34:0]  exp_v;
        int           wi;
        line = {32'h44, 32'h33, 32'h22, 32'h11};
        issue0(1'b0, 32'h40, '0);
        repeat (L0 + 2) tick();
        checks++;
        if (bus0.rvalid !== 1'b1 || bus0.rdata !== 32'h33) begin
            failures++;
            $display("FAIL abort_beat2 got %b %h exp 1 00000033", bus0.rvalid, bus0.rdata);
        end
        cpu_rstn = 1'b1;
        tick();
        checks++;
        if ({bus0.rvalid, bus0.rlast, bus0.wdone, bus0.mready, bus0.rdata, rdc0, wrc0}
            !== {4'b0001, 32'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL abort_outputs got v/l/w/r=%b%b%b%b data=%h rd=%0d wr=%0d exp 0001 0 0 0",
                     bus0.rvalid, bus0.rlast, bus0.wdone, bus0.mready, bus0.rdata, rdc0, wrc0);
        end
        cpu_rstn = 1'b0;
        exp_rd = 0;
        tick();
        // Reset lands on the commit edge of a writeback: nothing may be stored.
        issue0(1'b1, 32'h40, {4{32'hDEAD_BEEF}});
        repeat (L0 - 1) tick();
        cpu_rstn = 1'b1;
        tick();
        cpu_rstn = 1'b0;
        tick();
        checks++;
        if (bus0.wdone !== 1'b0 || bus0.mready !== 1'b1) begin
            failures++;
            $display("FAIL abort_write_state got wdone=%b mready=%b exp 0 1", bus0.wdone, bus0.mready);
        end
        issue0(1'b0, 32'h40, '0);
        exp_rd++;
        for (int j = 0; j <= L0 + 4; j++) begin
            wi = (j - L0) & 3;
            exp_v[34] = (j >= L0 && j <= L0 + 3);
            exp_v[33] = (j == L0 + 3);
            exp_v[32] = (j == L0 + 4);
            exp_v[31:0] = exp_v[34] ? line[32*wi +: 32] : 32'd0;
            checks++;
            if ({bus0.rvalid, bus0.rlast, bus0.mready, bus0.rdata} !== exp_v) begin
                failures++;
                $display("FAIL abort_reread j=%0d got v/l/r=%b%b%b data=%h exp %b data=%h",
                         j, bus0.rvalid, bus0.rlast, bus0.mready, bus0.rdata, exp_v[34:32], exp_v[31:0]);
            end
            if (j < L0 + 4) tick();
        end
    endtask

    task automatic test_alias();
        logic [127:0] line;
        line = {32'hD0D0_0004, 32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
        issue0(1'b1, 32'h400, line);
        repeat (L0 + 1) tick();
        dpra0 = 32'h408; #1;
        checks++;
        if (dpo0 !== 32'hC0C0_0003) begin
            failures++;
            $display("FAIL alias_dpo got %h exp c0c00003", dpo0);
        end
        issue0(1'b0, 32'h000, '0);
        repeat (L0) tick();
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (bus0.rvalid !== 1'b1 || bus0.rdata !== line[32*b +: 32]) begin
                failures++;
                $display("FAIL alias_beat b=%0d got %b %h exp 1 %h", b, bus0.rvalid, bus0.rdata, line[32*b +: 32]);
            end
            tick();
        end
    endtask

    task automatic test_lat1();
        logic [127:0] line;
        logic [34:0]  exp_v;
        int           wi;
        line = {32'h4444_0000, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
        bus1.mreq = 1'b1; bus1.mrw = 1'b1; bus1.maddr = 32'h10; bus1.wline = line;
        tick();
        bus1.mreq = 1'b0; bus1.mrw = 1'b0; bus1.wline = '0;
        for (int j = 0; j <= L1 + 1; j++) begin
            checks++;
            if ({bus1.wdone, bus1.mready} !== {(j == L1), (j == L1 + 1)}) begin
                failures++;
                $display("FAIL lat1_write j=%0d got wdone/mready=%b%b exp %b%b",
                         j, bus1.wdone, bus1.mready, (j == L1), (j == L1 + 1));
            end
            if (j <= L1) tick();
        end
        bus1.mreq = 1'b1; bus1.maddr = 32'h14;
        tick();
        bus1.mreq = 1'b0;
        for (int j = 0; j <= L1 + 4; j++) begin
            wi = (j - L1) & 3;
            exp_v[34] = (j >= L1 && j <= L1 + 3);
            exp_v[33] = (j == L1 + 3);
            exp_v[32] = (j == L1 + 4);
            exp_v[31:0] = exp_v[34] ? line[32*wi +: 32] : 32'd0;
            checks++;
            if ({bus1.rvalid, bus1.rlast, bus1.mready, bus1.rdata} !== exp_v) begin
                failures++;
                $display("FAIL lat1_read j=%0d got v/l/r=%b%b%b data=%h exp %b data=%h",
                         j, bus1.rvalid, bus1.rlast, bus1.mready, bus1.rdata, exp_v[34:32], exp_v[31:0]);
            end
            if (j < L1 + 4) tick();
        end
        checks++;
        if (rdc1 !== 32'd1 || wrc1 !== 32'd1) begin
            failures++;
            $display("FAIL lat1_counts got rd=%0d wr=%0d exp 1 1", rdc1, wrc1);
        end
    endtask

    initial begin
        cpu_rstn = 1'b1;
        bus0.mreq = 1'b0; bus0.mrw = 1'b0; bus0.maddr = '0; bus0.wline = '0;
        bus1.mreq = 1'b0; bus1.mrw = 1'b0; bus1.maddr = '0; bus1.wline = '0;
        dpra0 = '0; dpra1 = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_abort();
        test_alias();
        test_lat1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
